// File: rtl/nvme_pkg.sv
// nvme_pkg: shared definitions for the NVMe submission-queue writer.
//   sq_state_t : writer FSM states.
//   DW_*       : dword offsets of the fields inside a 64-byte SQ entry.
//   SQE_BYTES  : size of one SQ entry in bytes.
//   sq_cmd_t   : command fields latched at the command handshake.
package nvme_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_SQE = 2'd1,
        WR_DB  = 2'd2
    } sq_state_t;

    localparam int SQE_BYTES = 64;

    localparam logic [3:0] DW_CDW0    = 4'd0;
    localparam logic [3:0] DW_NSID    = 4'd1;
    localparam logic [3:0] DW_PRP1_LO = 4'd6;
    localparam logic [3:0] DW_PRP1_HI = 4'd7;
    localparam logic [3:0] DW_SLBA_LO = 4'd10;
    localparam logic [3:0] DW_SLBA_HI = 4'd11;
    localparam logic [3:0] DW_NLB     = 4'd12;
    localparam logic [3:0] DW_LAST    = 4'd15;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] cid;
        logic [31:0] nsid;
        logic [63:0] slba;
        logic [15:0] nlb;
        logic [63:0] prp1;
    } sq_cmd_t;

endpackage

// File: rtl/nvme_sqe_mux.sv
// nvme_sqe_mux: combinational selection of one 32-bit dword of an SQ entry.
//   cmd   in  latched command fields
//   dw    in  dword index 0..15 within the entry
//   dword out dword value; reserved dwords read as zero
module nvme_sqe_mux
    import nvme_pkg::*;
(
    input  sq_cmd_t     cmd,
    input  logic [3:0]  dw,
    output logic [31:0] dword
);

    always_comb begin
        dword = '0;
        case (dw)
            DW_CDW0:    dword = {cmd.cid, 8'h00, cmd.opcode};
            DW_NSID:    dword = cmd.nsid;
            DW_PRP1_LO: dword = cmd.prp1[31:0];
            DW_PRP1_HI: dword = cmd.prp1[63:32];
            DW_SLBA_LO: dword = cmd.slba[31:0];
            DW_SLBA_HI: dword = cmd.slba[63:32];
            DW_NLB:     dword = {16'h0000, cmd.nlb};
            default:    dword = '0;
        endcase
    end

endmodule

// File: rtl/nvme_sq_writer.sv
// nvme_sq_writer: accepts one NVMe command at a time, writes the 16-dword
// submission-queue entry at the current tail over Avalon-MM, then rings the
// SQ tail doorbell and advances the tail.
//   clk_clk, reset_reset        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*  command handshake and fields
//   sq_head                     controller-reported head (used for full test)
//   avm_*                       Avalon-MM write master
//   sq_tail, sq_full, busy      status
module nvme_sq_writer
    import nvme_pkg::*;
#(
    parameter int          SQ_DEPTH = 16,
    parameter logic [31:0] SQ_BASE  = 32'h0000_0000,
    parameter logic [31:0] DB_ADDR  = 32'h0000_1000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [15:0] cmd_cid,
    input  logic [31:0] cmd_nsid,
    input  logic [63:0] cmd_slba,
    input  logic [15:0] cmd_nlb,
    input  logic [63:0] cmd_prp1,
    input  logic [7:0]  sq_head,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    output logic [7:0]  sq_tail,
    output logic        sq_full,
    output logic        busy
);

    localparam int TW = $clog2(SQ_DEPTH);

    sq_state_t     state, state_nxt;
    logic [3:0]    dw;
    logic [TW-1:0] tail;
    logic [TW-1:0] new_tail;
    sq_cmd_t       cmd_q;
    logic [31:0]   sqe_dword;
    logic [31:0]   sqe_addr;
    logic          xfer;
    logic          beat_done;

    // SQ_DEPTH is a power of two, so the TW-bit add wraps at SQ_DEPTH for free.
    assign new_tail  = tail + TW'(1);
    assign sq_tail   = 8'(tail);
    assign sq_full   = (8'(new_tail) == sq_head);
    assign xfer      = cmd_valid & cmd_ready;
    assign beat_done = avm_write & ~avm_waitrequest;
    assign sqe_addr  = SQ_BASE + 32'(tail) * 32'(SQE_BYTES) + {26'd0, dw, 2'b00};

    nvme_sqe_mux u_sqe_mux (
        .cmd   (cmd_q),
        .dw    (dw),
        .dword (sqe_dword)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus outputs are decoded from registered state only, so they stay
    // stable across waitrequest stalls and drop to zero the instant reset
    // forces IDLE.
    always_comb begin
        state_nxt      = state;
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        avm_byteenable = '0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = ~sq_full;
                if (cmd_valid && !sq_full) begin
                    state_nxt = WR_SQE;
                end
            end
            WR_SQE: begin
                avm_write      = 1'b1;
                avm_address    = sqe_addr;
                avm_writedata  = sqe_dword;
                avm_byteenable = 4'hF;
                if (!avm_waitrequest && dw == DW_LAST) begin
                    state_nxt = WR_DB;
                end
            end
            WR_DB: begin
                avm_write      = 1'b1;
                avm_address    = DB_ADDR;
                avm_writedata  = 32'(new_tail);
                avm_byteenable = 4'hF;
                if (!avm_waitrequest) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            dw   <= '0;
            tail <= '0;
        end else begin
            if (xfer) begin
                dw <= '0;
            end else if (state == WR_SQE && beat_done) begin
                dw <= dw + 4'd1;
            end
            if (state == WR_DB && beat_done) begin
                tail <= new_tail;
            end
        end
    end

    // Command fields are pure data: captured on the handshake, never reset.
    always_ff @(posedge clk_clk) begin
        if (xfer) begin
            cmd_q.opcode <= cmd_opcode;
            cmd_q.cid    <= cmd_cid;
            cmd_q.nsid   <= cmd_nsid;
            cmd_q.slba   <= cmd_slba;
            cmd_q.nlb    <= cmd_nlb;
            cmd_q.prp1   <= cmd_prp1;
        end
    end

endmodule
